// File: rtl/regfile_cmd_issuer.sv
// Regfile initiator: queues read/write requests, issues one encoded instruction per cycle,
// returns rs1/rs2 values via a 2-entry response FIFO; issue is credit-gated so responses never overflow.
module regfile_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [4:0]    req_rd,
  input  logic [4:0]    req_rs1,
  input  logic [4:0]    req_rs2,
  input  logic [DW-1:0] req_wdata,
  output logic [15:0]   inst,
  output logic [DW-1:0] data,
  input  logic [DW-1:0] rdata1,
  input  logic [DW-1:0] rdata2,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rs1,
  output logic [DW-1:0] rsp_rs2,
  output logic [7:0]    issued_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] REQ_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic          we;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
  } rsp_t;

  req_t          req_mem_q [DEPTH];
  req_t          req_mem_d [DEPTH];
  logic [AW-1:0] req_wptr_q, req_wptr_d;
  logic [AW-1:0] req_rptr_q, req_rptr_d;
  logic [AW:0]   req_cnt_q, req_cnt_d;

  logic          exec_valid_q, exec_valid_d;
  logic [15:0]   inst_q, inst_d;
  logic [DW-1:0] data_q, data_d;

  rsp_t          rsp_mem_q [2];
  rsp_t          rsp_mem_d [2];
  logic          rsp_wptr_q, rsp_wptr_d;
  logic          rsp_rptr_q, rsp_rptr_d;
  logic [1:0]    rsp_cnt_q, rsp_cnt_d;

  logic [7:0]    issued_q, issued_d;

  logic          req_push;
  logic          pop_ok;
  logic          rsp_pop;
  logic [2:0]    credit;
  req_t          head;

  assign req_ready  = (req_cnt_q != REQ_FULL);
  assign rsp_valid  = (rsp_cnt_q != 2'd0);
  assign inst       = inst_q;
  assign data       = data_q;
  assign rsp_rs1    = rsp_mem_q[rsp_rptr_q].rs1;
  assign rsp_rs2    = rsp_mem_q[rsp_rptr_q].rs2;
  assign issued_cnt = issued_q;

  always_comb begin
    req_push   = req_valid && req_ready;
    rsp_pop    = rsp_valid && rsp_ready;
    // Occupancy the response FIFO will have after this edge, excluding any new issue.
    credit     = {1'b0, rsp_cnt_q} + {2'b00, exec_valid_q} - {2'b00, rsp_pop};
    pop_ok     = (req_cnt_q != '0) && (credit < 3'd2);
    head       = req_mem_q[req_rptr_q];

    req_mem_d  = req_mem_q;
    req_wptr_d = req_wptr_q;
    req_rptr_d = req_rptr_q;
    req_cnt_d  = req_cnt_q;
    if (req_push) begin
      req_mem_d[req_wptr_q] = '{we: req_we, rd: req_rd, rs1: req_rs1, rs2: req_rs2, wdata: req_wdata};
      req_wptr_d = req_wptr_q + AW'(1);
    end
    if (pop_ok) begin
      req_rptr_d = req_rptr_q + AW'(1);
    end
    case ({req_push, pop_ok})
      2'b10:   req_cnt_d = req_cnt_q + (AW+1)'(1);
      2'b01:   req_cnt_d = req_cnt_q - (AW+1)'(1);
      default: req_cnt_d = req_cnt_q;
    endcase

    // Writes to x0 still travel the pipe and produce a response, but never assert writeEn.
    exec_valid_d = pop_ok;
    inst_d       = '0;
    data_d       = '0;
    if (pop_ok) begin
      inst_d = {head.we && (head.rd != 5'd0), head.rd, head.rs2, head.rs1};
      data_d = head.wdata;
    end

    rsp_mem_d  = rsp_mem_q;
    rsp_wptr_d = rsp_wptr_q;
    rsp_rptr_d = rsp_rptr_q;
    rsp_cnt_d  = rsp_cnt_q;
    if (exec_valid_q) begin
      rsp_mem_d[rsp_wptr_q] = '{rs1: rdata1, rs2: rdata2};
      rsp_wptr_d = ~rsp_wptr_q;
    end
    if (rsp_pop) begin
      rsp_rptr_d = ~rsp_rptr_q;
    end
    case ({exec_valid_q, rsp_pop})
      2'b10:   rsp_cnt_d = rsp_cnt_q + 2'd1;
      2'b01:   rsp_cnt_d = rsp_cnt_q - 2'd1;
      default: rsp_cnt_d = rsp_cnt_q;
    endcase

    issued_d = issued_q + {7'b0, exec_valid_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) req_mem_q[i] <= '0;
      req_wptr_q   <= '0;
      req_rptr_q   <= '0;
      req_cnt_q    <= '0;
      exec_valid_q <= 1'b0;
      inst_q       <= '0;
      data_q       <= '0;
      for (int i = 0; i < 2; i++) rsp_mem_q[i] <= '0;
      rsp_wptr_q   <= 1'b0;
      rsp_rptr_q   <= 1'b0;
      rsp_cnt_q    <= '0;
      issued_q     <= '0;
    end else begin
      req_mem_q    <= req_mem_d;
      req_wptr_q   <= req_wptr_d;
      req_rptr_q   <= req_rptr_d;
      req_cnt_q    <= req_cnt_d;
      exec_valid_q <= exec_valid_d;
      inst_q       <= inst_d;
      data_q       <= data_d;
      rsp_mem_q    <= rsp_mem_d;
      rsp_wptr_q   <= rsp_wptr_d;
      rsp_rptr_q   <= rsp_rptr_d;
      rsp_cnt_q    <= rsp_cnt_d;
      issued_q     <= issued_d;
    end
  end

endmodule

// File: tb/tb_regfile_cmd_issuer.sv
// Bench for regfile_cmd_issuer: regfile model, in-order scoreboard fed at request acceptance,
// table-driven encoding vectors, directed backpressure/throughput/reset/wrap sequences and random traffic.
module tb_regfile_cmd_issuer;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [4:0]    req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [15:0]   inst;
  logic [DW-1:0] data, rdata1, rdata2;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rs1, rsp_rs2;
  logic [7:0]    issued_cnt;

  always #5 clk = ~clk;

  regfile_cmd_issuer #(.DEPTH(4), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_wdata(req_wdata),
    .inst(inst), .data(data), .rdata1(rdata1), .rdata2(rdata2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rs1(rsp_rs1), .rsp_rs2(rsp_rs2),
    .issued_cnt(issued_cnt)
  );

  // Regfile: combinational reads, write at the clock edge ending the exec cycle.
  logic [31:0] rf [32] = '{default: 32'h0};
  int rf_writes = 0;
  assign rdata1 = rf[inst[4:0]];
  assign rdata2 = rf[inst[9:5]];
  always @(posedge clk) begin
    if (inst[15]) begin
      rf[inst[14:10]] <= data;
      rf_writes++;
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: architectural register image advanced in request order.
  typedef struct { logic [15:0] inst; logic [31:0] data; } exec_t;
  typedef struct { logic [31:0] rs1; logic [31:0] rs2; } rsp_t;
  exec_t       exp_exec_q[$];
  rsp_t        exp_rsp_q[$];
  logic [31:0] shadow [32];
  int          acc_cyc[$];
  int          rsp_cyc[$];
  int          exec_seen = 0;
  logic [15:0] last_exec_inst = '0;

  logic        have_prev = 1'b0, resync = 1'b1;
  logic [15:0] p_inst;
  logic [31:0] p_data, p_r1, p_r2;
  logic [7:0]  p_cnt, delta;
  logic        p_rv, p_rr;
  exec_t       m_e;
  rsp_t        m_r;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_exec_q.delete();
      exp_rsp_q.delete();
      have_prev = 1'b0;
      resync    = 1'b1;
    end else begin
      if (resync) begin
        for (int i = 0; i < 32; i++) shadow[i] = rf[i];
        resync = 1'b0;
      end
      if (have_prev) begin
        delta = issued_cnt - p_cnt;
        if (delta == 8'd1) begin
          exec_seen++;
          last_exec_inst = p_inst;
          if (exp_exec_q.size() == 0) fail_now("exec_without_request");
          else begin
            m_e = exp_exec_q.pop_front();
            check("exec_inst", {48'h0, p_inst}, {48'h0, m_e.inst});
            check("exec_data", {32'h0, p_data}, {32'h0, m_e.data});
          end
        end else if (delta == 8'd0) begin
          check("idle_bus_zero", {16'h0, p_inst, p_data}, 64'h0);
        end else begin
          check("issued_step", {56'h0, delta}, 64'd1);
        end
        if (p_rv && !p_rr) begin
          check("rsp_hold_valid", {63'h0, rsp_valid}, 64'd1);
          check("rsp_hold_data", {rsp_rs1, rsp_rs2}, {p_r1, p_r2});
        end
      end
      if (req_valid && req_ready) begin
        m_e.inst = {req_we && (req_rd != 5'd0), req_rd, req_rs2, req_rs1};
        m_e.data = req_wdata;
        exp_exec_q.push_back(m_e);
        m_r.rs1 = shadow[req_rs1];
        m_r.rs2 = shadow[req_rs2];
        exp_rsp_q.push_back(m_r);
        if (req_we && req_rd != 5'd0) shadow[req_rd] = req_wdata;
        acc_cyc.push_back(cyc);
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cyc.push_back(cyc);
        if (exp_rsp_q.size() == 0) fail_now("rsp_without_request");
        else begin
          m_r = exp_rsp_q.pop_front();
          check("rsp_data", {rsp_rs1, rsp_rs2}, {m_r.rs1, m_r.rs2});
        end
      end
      p_inst = inst; p_data = data; p_cnt = issued_cnt;
      p_rv = rsp_valid; p_rr = rsp_ready; p_r1 = rsp_rs1; p_r2 = rsp_rs2;
      have_prev = 1'b1;
    end
  end

  task automatic send_req(input logic we, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_wdata = wd;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        return;
      end
    end
    fail_now("req_accept_timeout");
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] wdata;
    logic [15:0] inst;
    logic [31:0] rs1v, rs2v;
  } vec_t;
  vec_t vecs[8];

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin : main
    logic got, acc, ok;
    logic [7:0] base;
    int w0, n0, e0;

    vecs[0] = '{1'b1, 5'd5,  5'd0,  5'd0,  32'hDEADBEEF, 16'h9400, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 5'd0,  5'd5,  5'd0,  32'h0,        16'h0005, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 5'd0,  5'd0,  5'd0,  32'h1,        16'h0000, 32'h0,        32'h0};
    vecs[3] = '{1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        16'h00A0, 32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd5,  5'd5,  5'd5,  32'h12345678, 16'h94A5, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 5'd0,  5'd5,  5'd5,  32'h0,        16'h00A5, 32'h12345678, 32'h12345678};
    vecs[6] = '{1'b1, 5'd31, 5'd31, 5'd1,  32'hCAFEF00D, 16'hFC3F, 32'h0,        32'h0};
    vecs[7] = '{1'b0, 5'd31, 5'd1,  5'd31, 32'h0,        16'h7FE1, 32'h0,        32'hCAFEF00D};

    #1 rst_n = 1'b0;
    #11;
    check("rst_req_ready", {63'h0, req_ready}, 64'd1);
    check("rst_inst",      {48'h0, inst}, 64'h0);
    check("rst_data",      {32'h0, data}, 64'h0);
    check("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    check("rst_rsp_data",  {rsp_rs1, rsp_rs2}, 64'h0);
    check("rst_issued",    {56'h0, issued_cnt}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    idle_cycles(2);

    // Encoding, write/read ordering, x0 writes and read-during-write.
    for (int i = 0; i < 8; i++) begin
      send_req(vecs[i].we, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].wdata);
      req_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        got = rsp_valid;
      end
      if (!got) fail_now("vec_rsp_timeout");
      else begin
        #1;
        check("vec_inst", {48'h0, last_exec_inst}, {48'h0, vecs[i].inst});
        check("vec_rsp",  {rsp_rs1, rsp_rs2}, {vecs[i].rs1v, vecs[i].rs2v});
      end
      @(posedge clk); #1;
    end
    idle_cycles(4);

    // Backpressure: two responses held, request FIFO fills.
    rsp_ready = 1'b0;
    base = issued_cnt;
    w0 = rf_writes;
    for (int i = 0; i < 6; i++) send_req(1'b1, 5'(i + 1), 5'(i), 5'(i + 1), $urandom);
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp_issued",    {56'h0, 8'(issued_cnt - base)}, 64'd2);
    check("bp_req_ready", {63'h0, req_ready}, 64'h0);
    check("bp_rsp_valid", {63'h0, rsp_valid}, 64'd1);
    check("bp_pending",   64'(exp_rsp_q.size()), 64'd6);
    @(posedge clk); #1;
    n0 = rsp_cyc.size();
    rsp_ready = 1'b1;
    idle_cycles(20);
    check("bp_drained", 64'(rsp_cyc.size() - n0), 64'd6);
    check("bp_writes",  64'(rf_writes - w0), 64'd6);

    // Throughput: back-to-back requests with an always-ready consumer.
    acc_cyc.delete();
    rsp_cyc.delete();
    for (int i = 0; i < 10; i++) send_req(i[0], 5'(i + 8), 5'(i), 5'(i + 8), 32'h1000 + i);
    idle_cycles(15);
    check("tp_accepts", 64'(acc_cyc.size()), 64'd10);
    check("tp_rsps",    64'(rsp_cyc.size()), 64'd10);
    if (acc_cyc.size() == 10 && rsp_cyc.size() == 10) begin
      check("tp_first_latency", 64'(rsp_cyc[0] - acc_cyc[0]), 64'd3);
      ok = 1'b1;
      for (int i = 1; i < 10; i++) if (rsp_cyc[i] != rsp_cyc[0] + i) ok = 1'b0;
      check("tp_consecutive", {63'h0, ok}, 64'd1);
    end

    // Asynchronous reset in the middle of a backed-up stream.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_req(1'b1, 5'(20 + i), 5'(i), 5'(i), $urandom);
    req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_inst",      {48'h0, inst}, 64'h0);
    check("mid_rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    check("mid_rst_issued",    {56'h0, issued_cnt}, 64'h0);
    check("mid_rst_req_ready", {63'h0, req_ready}, 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_rst_discard_rsp", {63'h0, rsp_valid}, 64'h0);
    check("mid_rst_discard_cnt", {56'h0, issued_cnt}, 64'h0);
    @(posedge clk); #1;

    // Random traffic against the scoreboard.
    acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!req_valid || acc) begin
        req_valid = ($urandom_range(0, 9) < 6);
        req_we    = 1'($urandom_range(0, 1));
        req_rd    = 5'($urandom_range(0, 7));
        req_rs1   = 5'($urandom_range(0, 7));
        req_rs2   = 5'($urandom_range(0, 7));
        req_wdata = $urandom;
      end
      rsp_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      acc = req_valid && req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    idle_cycles(15);
    check("rand_rsp_drained",  64'(exp_rsp_q.size()), 64'd0);
    check("rand_exec_drained", 64'(exp_exec_q.size()), 64'd0);

    // Counter wrap after 256 executions; idle cycles leave it alone.
    pulse_reset();
    e0 = exec_seen;
    for (int i = 0; i < 256; i++)
      send_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'(i), 5'(i + 3), $urandom);
    idle_cycles(10);
    @(negedge clk);
    check("wrap_execs",   64'(exec_seen - e0), 64'd256);
    check("wrap_issued",  {56'h0, issued_cnt}, 64'h0);
    repeat (8) @(negedge clk);
    check("wrap_idle_hold", {56'h0, issued_cnt}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
